// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the APB side of the I2C controller: requester FSM
// states, wait-counter width and the controller's register map.
package i2c_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int WAIT_CNT_W = 8;

  localparam logic [7:0] REG_TX         = 8'h00;
  localparam logic [7:0] REG_RX         = 8'h04;
  localparam logic [7:0] REG_STATUS     = 8'h08;
  localparam logic [7:0] REG_SLAVE_ADDR = 8'h0C;
  localparam logic [7:0] REG_COMMAND    = 8'h10;
  localparam logic [7:0] REG_PRESCALE   = 8'h14;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready; terminal marks the last
// cycle the requester may wait before aborting.
module apb_wait_timer
  import i2c_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/apb_master_interface.sv
// APB3 requester: one single-beat command at a time, SETUP/ACCESS phasing,
// pready wait states with timeout abort, and a one-cycle response strobe.
module apb_master_interface
  import i2c_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  apb_state_t state, state_next;
  logic       handshake, complete, abort, wait_term;

  assign handshake = cmd_valid_i && cmd_ready_o;
  assign complete  = (state == ACCESS) && pready_i;
  // Completion wins if pready rises in the final permitted wait cycle.
  assign abort     = (state == ACCESS) && !pready_i && wait_term;

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid_i) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (complete || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state == IDLE);
    psel_o      = (state != IDLE);
    penable_o   = (state == ACCESS);
  end

  // Command latch: drives the APB address/data phase and holds through IDLE.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
    end else if (handshake) begin
      paddr_o  <= cmd_addr_i;
      pwrite_o <= cmd_write_i;
      pwdata_o <= cmd_wdata_i;
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= complete || abort;
      rsp_err_o   <= abort;
      rsp_rdata_o <= (complete && !pwrite_o) ? prdata_i : '0;
    end
  end

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (pclk_i),
    .rst_n    (preset_ni),
    .clr      (handshake),
    .inc      ((state == ACCESS) && !pready_i),
    .terminal (wait_term)
  );

endmodule

// File: tb/tb_apb_master_interface.sv
// Bench for apb_master_interface: transaction-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_apb_master_interface;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [7:0] paddr, pwdata, prdata, rsp_rdata;
  logic       pwrite, psel, penable, pready, rsp_valid, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_interface #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk_i(clk), .preset_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: ready after wait_n low cycles of each ACCESS phase.
  int         wait_n  = 0;
  int         acc_cnt = 0;
  logic [7:0] prdata_v = 8'h00;
  assign pready = (acc_cnt >= wait_n);
  assign prdata = prdata_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          acc_cnt <= 0;
    else if (!penable)                   acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
  end

  // Model: after a handshake, cycle k=1 is SETUP, k>=2 is ACCESS number k-1.
  logic       m_busy, m_w, m_rv, m_re;
  int         m_k;
  logic [7:0] m_addr, m_wdata, m_rd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_k <= 0; m_w <= 0; m_addr <= 0; m_wdata <= 0;
      m_rv <= 0; m_re <= 0; m_rd <= 0;
    end else begin
      m_rv <= 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy <= 1; m_k <= 1;
          m_w <= cmd_write; m_addr <= cmd_addr; m_wdata <= cmd_wdata;
        end
      end else if (m_k >= 2 && (pready || (m_k - 1) == TO)) begin
        m_busy <= 0; m_rv <= 1; m_re <= !pready;
        m_rd <= (pready && !m_w) ? prdata : 8'h00;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  logic check_en = 1'b0;
  int   rsp_seen = 0;
  int   hs_cnt   = 0;
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_k >= 2);
      chk("paddr", paddr, m_addr);
      chk("pwrite", pwrite, m_w);
      chk("pwdata", pwdata, m_wdata);
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("rsp_err", rsp_err, m_re);
        chk("rsp_rdata", rsp_rdata, m_rd);
      end
    end
    if (rst_n && rsp_valid) rsp_seen++;
    if (rst_n && cmd_valid && cmd_ready) hs_cnt++;
  end

  int         acc, first_acc, rsp_at;
  logic [7:0] a_addr, a_wdata, r_data;
  logic       a_write, r_err, got;

  task automatic run_single(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_write = ~w; cmd_addr = 8'hFF; cmd_wdata = 8'hEE;
    acc = 0; first_acc = 0; rsp_at = 0; got = 0;
    a_addr = 0; a_wdata = 0; a_write = 0; r_data = 0; r_err = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (penable) begin
        acc++;
        if (first_acc == 0) begin
          first_acc = i; a_addr = paddr; a_wdata = pwdata; a_write = pwrite;
        end
      end
      if (rsp_valid) begin
        got = 1; rsp_at = i; r_err = rsp_err; r_data = rsp_rdata;
      end
    end
    if (!got) chk("rsp_never_arrived", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, rs0;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #2 rst_n = 1;
    check_en = 1;
    @(posedge clk); #1;

    // Zero-wait write of 0xA5 to PRESCALE
    wait_n = 0; prdata_v = 8'h99;
    run_single(1'b1, 8'h14, 8'hA5);
    chk("t1_first_access_cycle", first_acc, 2);
    chk("t1_access_cycles", acc, 1);
    chk("t1_rsp_cycle", rsp_at, 3);
    chk("t1_paddr", a_addr, 8'h14);
    chk("t1_pwdata", a_wdata, 8'hA5);
    chk("t1_pwrite", a_write, 1);
    chk("t1_rsp_err", r_err, 0);
    chk("t1_rsp_rdata", r_data, 8'h00);

    // Read STATUS with two wait states
    wait_n = 2; prdata_v = 8'h3C;
    run_single(1'b0, 8'h08, 8'h00);
    chk("t2_access_cycles", acc, 3);
    chk("t2_rsp_cycle", rsp_at, 5);
    chk("t2_paddr", a_addr, 8'h08);
    chk("t2_rsp_rdata", r_data, 8'h3C);
    chk("t2_rsp_err", r_err, 0);

    // Slave never ready: abort after TO access cycles
    wait_n = 99; prdata_v = 8'h77;
    run_single(1'b0, 8'h04, 8'h00);
    chk("t3_access_cycles", acc, 4);
    chk("t3_rsp_cycle", rsp_at, 6);
    chk("t3_rsp_err", r_err, 1);
    chk("t3_rsp_rdata", r_data, 8'h00);

    // Ready rises in the final permitted access cycle
    wait_n = 3; prdata_v = 8'h5A;
    run_single(1'b0, 8'h04, 8'h00);
    chk("t4_access_cycles", acc, 4);
    chk("t4_rsp_err", r_err, 0);
    chk("t4_rsp_rdata", r_data, 8'h5A);

    // Back-to-back writes with valid held high and junk while busy
    wait_n = 0;
    hs0 = hs_cnt; rs0 = rsp_seen;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h0C; cmd_wdata = 8'h50;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      cmd_write = 0; cmd_addr = 8'hF0 + 8'(k); cmd_wdata = 8'hE0 + 8'(k);
      @(posedge clk); #1;
      cmd_addr = 8'hC3;
      @(posedge clk); #1;
      cmd_write = 1;
      case (k)
        0: begin cmd_addr = 8'h10; cmd_wdata = 8'h80; end
        1: begin cmd_addr = 8'h00; cmd_wdata = 8'h11; end
        default: cmd_valid = 0;
      endcase
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_handshakes", hs_cnt - hs0, 3);
    chk("t5_responses", rsp_seen - rs0, 3);
    chk("t5_last_paddr", paddr, 8'h00);
    chk("t5_last_pwdata", pwdata, 8'h11);

    // Reset asserted mid-ACCESS
    wait_n = 99;
    rs0 = rsp_seen;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h10; cmd_wdata = 8'h00;
    @(posedge clk); #1 cmd_valid = 0;
    @(posedge clk); #1;
    chk("t6_in_access", penable, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_psel", psel, 0);
    chk("t6_penable", penable, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_paddr", paddr, 8'h00);
    @(posedge clk); @(posedge clk); #2 rst_n = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_no_response", rsp_seen - rs0, 0);
    chk("t6_ready_after", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_interface.md
# apb_master_interface

APB requester that turns single-beat register commands from a local sequencer (test controller or host bridge) into APB3 transfers toward the I2C controller's APB slave port. It owns the SETUP/ACCESS phasing, honours `pready` wait states and aborts with an error if the slave never answers. It returns read data and completion status on a one-cycle response strobe.

## Interface
- `DATA_WIDTH`, 8: width of `pwdata_o`, `prdata_i`, command write data and response read data.
- `ADDR_WIDTH`, 8: width of `paddr_o` and the command address.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles with `pready_i` low before abort. Legal range is 1..255.
- `pclk_i` in 1: clock. All logic is rising-edge.
- `preset_ni` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted on an edge where valid and ready are both high.
- `cmd_write_i` in 1: 1 selects a write, 0 selects a read.
- `cmd_addr_i` in ADDR_WIDTH: target register address.
- `cmd_wdata_i` in DATA_WIDTH: write data.
- `paddr_o` out ADDR_WIDTH: APB address.
- `pwrite_o` out 1: APB direction.
- `psel_o` out 1: APB select.
- `penable_o` out 1: APB enable.
- `pwdata_o` out DATA_WIDTH: APB write data.
- `prdata_i` in DATA_WIDTH: APB read data.
- `pready_i` in 1: APB ready.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out DATA_WIDTH: read data. Valid while `rsp_valid_o` is high.
- `rsp_err_o` out 1: timeout flag. Valid while `rsp_valid_o` is high.

## Operation
- FSM states:
  - IDLE: `cmd_ready_o`=1. On handshake, latch write, addr and wdata, then go to SETUP.
  - SETUP: `psel_o`=1, `penable_o`=0. Always go to ACCESS next cycle.
  - ACCESS: `psel_o`=1, `penable_o`=1. If `pready_i`=1, complete and go to IDLE. Else, if the wait counter equals `TIMEOUT_CYCLES`-1, abort and go to IDLE. Else stay and increment the counter.
- `paddr_o`, `pwrite_o` and `pwdata_o` come from the latched command. They are stable from SETUP through the end of ACCESS.
- In IDLE these outputs hold their last values. `psel_o` and `penable_o` are 0 in IDLE.
- `cmd_ready_o` is high only in IDLE. Exactly one transfer is outstanding at a time. There is no command buffering beyond the latch.
- On completion:
  - `rsp_valid_o`=1 for exactly one cycle, the first IDLE cycle.
  - `rsp_err_o`=0.
  - `rsp_rdata_o` = `prdata_i` sampled at the completing edge for reads, and 0 for writes.
- On abort: `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_rdata_o`=0.
- The response has no backpressure. The consumer must take it in that cycle.
- The wait counter is 8 bits wide. It clears on entry to SETUP and never wraps, because abort occurs at `TIMEOUT_CYCLES`-1.
- A new command may be accepted in the same IDLE cycle in which `rsp_valid_o` pulses.
- `cmd_*` inputs are ignored outside IDLE.

## Timing
- Reset values: `cmd_ready_o`=1, `psel_o`=0, `penable_o`=0, `pwrite_o`=0, `paddr_o`=0, `pwdata_o`=0, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, state IDLE.
- Reset asserted mid-transfer forces all of the above immediately, without waiting for a clock. The in-flight command is dropped and no response is produced.
- Zero-wait transfer with handshake at edge N:
  - SETUP runs in cycle N+1.
  - ACCESS runs in cycle N+2.
  - The response pulse is in cycle N+3.
- Throughput is 3 cycles per zero-wait transfer. Each wait state adds one cycle.
- Read data is captured on the edge where `penable_o`=1 and `pready_i`=1. This matches the slave, which registers `prdata` at the SETUP edge.
- Timeout: abort on the edge ending the `TIMEOUT_CYCLES`-th ACCESS cycle with `pready_i` low. If `pready_i` rises in that same cycle, completion wins over abort.

## Structure
- Shared package `i2c_apb_pkg` holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - register address constants: TX 0x00, RX 0x04, STATUS 0x08, SLAVE_ADDR 0x0C, COMMAND 0x10, PRESCALE 0x14.
- Sub-module `apb_wait_timer` holds the wait counter, with clear and increment inputs and a terminal flag. Everything else lives in the top module.

## Test plan
- Write 0xA5 to 0x14 against a slave with `pready_i`=1. Expect SETUP at N+1, ACCESS at N+2 with `paddr_o`=0x14, `pwdata_o`=0xA5, `pwrite_o`=1; `rsp_valid_o` at N+3 with `rsp_err_o`=0 and `rsp_rdata_o`=0.
- Read 0x08 with the slave returning 0x3C after 2 wait states. Expect ACCESS held 3 cycles with address stable; response `rsp_rdata_o`=0x3C, `rsp_err_o`=0.
- `pready_i` tied 0, `TIMEOUT_CYCLES`=4. Expect ACCESS lasts exactly 4 cycles, then `psel_o`=0 and `rsp_valid_o`=1 with `rsp_err_o`=1, `rsp_rdata_o`=0.
- `pready_i` rises in the 4th ACCESS cycle, `TIMEOUT_CYCLES`=4. Expect normal completion with `rsp_err_o`=0.
- `cmd_valid_i` held high for 3 writes (0x0C=0x50, 0x10=0x80, 0x00=0x11). Expect one handshake per IDLE, transfers issued back-to-back every 3 cycles in order, and `cmd_*` changes during SETUP/ACCESS ignored.
- Assert `preset_ni` during ACCESS. Expect `psel_o`, `penable_o` and `rsp_valid_o` go to 0 immediately; after release, `cmd_ready_o`=1 and no response is produced.
